// File: rtl/bidir_bus_delay_if.sv
// Split-pin bus bundle between the bench and bidir_bus_delay.
// Defining BIDIR_DELAY_RUNTIME_EN adds the dly_ab_i/dly_ba_i latency inputs.
interface bidir_bus_delay_if #(
  parameter int WIDTH     = 8,
  parameter int MAX_DELAY = 16
);
  logic             a_oe_i;
  logic [WIDTH-1:0] a_dat_i;
  logic             a_oe_o;
  logic [WIDTH-1:0] a_dat_o;
  logic             b_oe_i;
  logic [WIDTH-1:0] b_dat_i;
  logic             b_oe_o;
  logic [WIDTH-1:0] b_dat_o;
  logic [1:0]       dir_o;
  logic             contention_o;
  logic [15:0]      cont_cnt_o;

`ifdef BIDIR_DELAY_RUNTIME_EN
  localparam int DW = $clog2(MAX_DELAY + 1);
  logic [DW-1:0]    dly_ab_i;
  logic [DW-1:0]    dly_ba_i;

  modport slave (
    input  a_oe_i, a_dat_i, b_oe_i, b_dat_i, dly_ab_i, dly_ba_i,
    output a_oe_o, a_dat_o, b_oe_o, b_dat_o, dir_o, contention_o, cont_cnt_o
  );
  modport master (
    output a_oe_i, a_dat_i, b_oe_i, b_dat_i, dly_ab_i, dly_ba_i,
    input  a_oe_o, a_dat_o, b_oe_o, b_dat_o, dir_o, contention_o, cont_cnt_o
  );
`else
  modport slave (
    input  a_oe_i, a_dat_i, b_oe_i, b_dat_i,
    output a_oe_o, a_dat_o, b_oe_o, b_dat_o, dir_o, contention_o, cont_cnt_o
  );
  modport master (
    output a_oe_i, a_dat_i, b_oe_i, b_dat_i,
    input  a_oe_o, a_dat_o, b_oe_o, b_dat_o, dir_o, contention_o, cont_cnt_o
  );
`endif
endinterface

// File: rtl/bidir_bus_delay.sv
// Clocked bidirectional bus delay: owns bus direction, delays each direction, enforces turnaround.
// Optional BIDIR_DELAY_RUNTIME_EN: per-direction latency latched from dly_*_i on leaving IDLE.
module bidir_bus_delay #(
  parameter int WIDTH      = 8,
  parameter int DELAY_AB   = 2,
  parameter int DELAY_BA   = 3,
  parameter int TURNAROUND = 1,
  parameter int MAX_DELAY  = 16
) (
  input logic              clk,
  input logic              rst_n,
  bidir_bus_delay_if.slave bus
);
  localparam int DW = $clog2(MAX_DELAY + 1);
  localparam int AW = $clog2(MAX_DELAY);

  typedef enum logic [1:0] {IDLE = 2'd0, FWD = 2'd1, REV = 2'd2, TURN = 2'd3} dir_t;

  dir_t                 r_state;
  dir_t                 w_nextState;
  logic [3:0]           r_turnCnt;
  logic [MAX_DELAY-1:0] r_abVld;
  logic [MAX_DELAY-1:0] r_baVld;
  logic [WIDTH-1:0]     r_abDat [MAX_DELAY];
  logic [WIDTH-1:0]     r_baDat [MAX_DELAY];
  logic [DW-1:0]        w_abTap;
  logic [DW-1:0]        w_baTap;
  logic [AW-1:0]        w_abIdx;
  logic [AW-1:0]        w_baIdx;
  logic [MAX_DELAY-1:0] w_abMask;
  logic [MAX_DELAY-1:0] w_baMask;
  logic                 w_abBusy;
  logic                 w_baBusy;
  logic                 w_accAb;
  logic                 w_accBa;
  logic                 w_cont;
  logic                 r_contention;
  logic [15:0]          r_contCnt;

`ifdef BIDIR_DELAY_RUNTIME_EN
  logic [DW-1:0] r_abTap;
  logic [DW-1:0] r_baTap;

  function automatic logic [DW-1:0] clampDly(input logic [DW-1:0] d);
    if (d == '0) return DW'(1);
    if (d > DW'(MAX_DELAY)) return DW'(MAX_DELAY);
    return d;
  endfunction

  // Latency is frozen for the whole ownership, sampled only on the IDLE exit edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_abTap <= DW'(DELAY_AB);
      r_baTap <= DW'(DELAY_BA);
    end else if (r_state == IDLE) begin
      if (w_nextState == FWD) r_abTap <= clampDly(bus.dly_ab_i);
      if (w_nextState == REV) r_baTap <= clampDly(bus.dly_ba_i);
    end
  end

  assign w_abTap = r_abTap;
  assign w_baTap = r_baTap;
`else
  assign w_abTap = DW'(DELAY_AB);
  assign w_baTap = DW'(DELAY_BA);
`endif

  assign w_abIdx = AW'(w_abTap - DW'(1));
  assign w_baIdx = AW'(w_baTap - DW'(1));

  // Stages that will still sit at or before the tap after the next shift.
  always_comb begin
    w_abMask = '0;
    w_baMask = '0;
    for (int i = 0; i < MAX_DELAY; i++) begin
      w_abMask[i] = (i + 1 < int'(w_abTap));
      w_baMask[i] = (i + 1 < int'(w_baTap));
    end
  end

  assign w_abBusy = |(r_abVld & w_abMask);
  assign w_baBusy = |(r_baVld & w_baMask);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_turnCnt <= '0;
    end else begin
      r_state <= w_nextState;
      if (w_nextState == TURN && r_state != TURN) r_turnCnt <= 4'(TURNAROUND);
      else if (r_state == TURN)                   r_turnCnt <= r_turnCnt - 4'd1;
    end
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE: begin
        if (bus.a_oe_i && !bus.b_oe_i)      w_nextState = FWD;
        else if (bus.b_oe_i && !bus.a_oe_i) w_nextState = REV;
      end
      FWD:  if (!bus.a_oe_i && !w_abBusy) w_nextState = (TURNAROUND == 0) ? IDLE : TURN;
      REV:  if (!bus.b_oe_i && !w_baBusy) w_nextState = (TURNAROUND == 0) ? IDLE : TURN;
      TURN: if (r_turnCnt <= 4'd1) w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  // Owner side is sampled every cycle (gaps included); the other side only contends.
  always_comb begin
    w_accAb = 1'b0;
    w_accBa = 1'b0;
    w_cont  = 1'b0;
    case (r_state)
      IDLE: begin
        w_accAb = bus.a_oe_i && !bus.b_oe_i;
        w_accBa = bus.b_oe_i && !bus.a_oe_i;
        w_cont  = bus.a_oe_i && bus.b_oe_i;
      end
      FWD: begin
        w_accAb = bus.a_oe_i;
        w_cont  = bus.b_oe_i;
      end
      REV: begin
        w_accBa = bus.b_oe_i;
        w_cont  = bus.a_oe_i;
      end
      TURN:    w_cont = bus.a_oe_i || bus.b_oe_i;
      default: w_cont = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_abVld <= '0;
      r_baVld <= '0;
      for (int i = 0; i < MAX_DELAY; i++) begin
        r_abDat[i] <= '0;
        r_baDat[i] <= '0;
      end
    end else begin
      r_abVld    <= {r_abVld[MAX_DELAY-2:0], w_accAb};
      r_baVld    <= {r_baVld[MAX_DELAY-2:0], w_accBa};
      r_abDat[0] <= w_accAb ? bus.a_dat_i : '0;
      r_baDat[0] <= w_accBa ? bus.b_dat_i : '0;
      for (int i = 1; i < MAX_DELAY; i++) begin
        r_abDat[i] <= r_abDat[i-1];
        r_baDat[i] <= r_baDat[i-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_contention <= 1'b0;
      r_contCnt    <= '0;
    end else begin
      r_contention <= w_cont;
      if (w_cont && r_contCnt != 16'hFFFF) r_contCnt <= r_contCnt + 16'd1;
    end
  end

  assign bus.b_oe_o       = r_abVld[w_abIdx];
  assign bus.b_dat_o      = r_abVld[w_abIdx] ? r_abDat[w_abIdx] : '0;
  assign bus.a_oe_o       = r_baVld[w_baIdx];
  assign bus.a_dat_o      = r_baVld[w_baIdx] ? r_baDat[w_baIdx] : '0;
  assign bus.dir_o        = r_state;
  assign bus.contention_o = r_contention;
  assign bus.cont_cnt_o   = r_contCnt;
endmodule
